// File: rtl/main_decoder_fsm.sv
// RV32I main decoder with registered controls, LSU wait handling and trap flags.
// Handshake: an instruction transfers on a rising edge where instr_valid && in_ready; in_ready is high only in RUN.
module main_decoder_fsm #(
    parameter int AOP_W       = 5,
    parameter int MEMI_W      = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter bit SYS_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              in_ready,
    input  logic              mem_ready,
    input  logic              trap_ack,
    output logic              dec_valid,
    output logic [1:0]        srcA,
    output logic [2:0]        srcB,
    output logic [AOP_W-1:0]  aop,
    output logic [MEMI_W-1:0] memi,
    output logic              mwe,
    output logic              rfwe,
    output logic              ws,
    output logic              jal,
    output logic              jalr,
    output logic              b,
    output logic              enpc,
    output logic              illegal,
    output logic              mem_fault,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_TRAP     = 2'd2
    } state_t;

    typedef struct packed {
        logic              dec_valid;
        logic [1:0]        srca;
        logic [2:0]        srcb;
        logic [AOP_W-1:0]  aop;
        logic [MEMI_W-1:0] memi;
        logic              mwe;
        logic              rfwe;
        logic              ws;
        logic              jal;
        logic              jalr;
        logic              b;
        logic              enpc;
    } ctrl_t;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d, dec;
    logic              dec_illegal, dec_mem;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    // Pure decode of the presented word; the FSM decides whether it is used.
    always_comb begin
        dec           = '0;
        dec_illegal   = 1'b0;
        dec_mem       = 1'b0;
        dec.dec_valid = 1'b1;
        dec.enpc      = 1'b1;
        dec.aop       = AOP_W'(f3);
        if (instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    if (f7 == 7'h00 || f7 == 7'h20) begin
                        dec.rfwe     = 1'b1;
                        dec.aop[4:3] = instr[31:30];
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    dec.srcb = 3'd1;
                    dec.rfwe = 1'b1;
                    if (f3 == 3'b101) dec.aop[4:3] = instr[31:30];
                end
                // Loads hold rfwe low until the data returns; ws marks the pending write.
                OPC_LOAD: begin
                    dec.srcb = 3'd1;
                    dec.ws   = 1'b1;
                    dec.memi = MEMI_W'({2'b10, f3});
                    dec.enpc = 1'b0;
                    dec_mem  = 1'b1;
                end
                OPC_STORE: begin
                    dec.srcb = 3'd3;
                    dec.memi = MEMI_W'({2'b11, f3});
                    dec.mwe  = 1'b1;
                    dec.enpc = 1'b0;
                    dec_mem  = 1'b1;
                end
                OPC_BRANCH: begin
                    dec.b        = 1'b1;
                    dec.aop[4:3] = 2'b11;
                end
                OPC_JAL: begin
                    dec.srca = 2'd1;
                    dec.srcb = 3'd4;
                    dec.rfwe = 1'b1;
                    dec.jal  = 1'b1;
                end
                OPC_JALR: begin
                    if (f3 == 3'b000) begin
                        dec.srca = 2'd1;
                        dec.srcb = 3'd4;
                        dec.rfwe = 1'b1;
                        dec.jalr = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_LUI: begin
                    dec.srca = 2'd2;
                    dec.srcb = 3'd2;
                    dec.rfwe = 1'b1;
                end
                OPC_AUIPC: begin
                    dec.srca = 2'd1;
                    dec.srcb = 3'd2;
                    dec.rfwe = 1'b1;
                end
                OPC_MISC_MEM: dec.aop = '0;
                OPC_SYSTEM: begin
                    if (SYS_EN) dec.aop = '0;
                    else        dec_illegal = 1'b1;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl_d    = '0;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_RUN: begin
                if (instr_valid) begin
                    if (dec_illegal) begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end else if (dec_mem) begin
                        state_d = S_MEM_WAIT;
                        ctrl_d  = dec;
                        cnt_d   = '0;
                    end else begin
                        ctrl_d = dec;
                    end
                end
            end
            S_MEM_WAIT: begin
                // Completion is checked before expiry so a late mem_ready still wins.
                if (mem_ready) begin
                    ctrl_d      = ctrl_q;
                    ctrl_d.memi = '0;
                    ctrl_d.mwe  = 1'b0;
                    ctrl_d.rfwe = ctrl_q.ws;
                    ctrl_d.enpc = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_RUN;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    fault_d = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    ctrl_d = ctrl_q;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            S_TRAP: begin
                if (trap_ack) begin
                    illegal_d = 1'b0;
                    fault_d   = 1'b0;
                    state_d   = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign state_dbg = state_q;
    assign dec_valid = ctrl_q.dec_valid;
    assign srcA      = ctrl_q.srca;
    assign srcB      = ctrl_q.srcb;
    assign aop       = ctrl_q.aop;
    assign memi      = ctrl_q.memi;
    assign mwe       = ctrl_q.mwe;
    assign rfwe      = ctrl_q.rfwe;
    assign ws        = ctrl_q.ws;
    assign jal       = ctrl_q.jal;
    assign jalr      = ctrl_q.jalr;
    assign b         = ctrl_q.b;
    assign enpc      = ctrl_q.enpc;
    assign illegal   = illegal_q;
    assign mem_fault = fault_q;

endmodule

// File: tb/tb_main_decoder_fsm.sv
// Bench for main_decoder_fsm: directed scenarios plus random instruction streams
// checked against an instruction-class model of the expected control outputs.
module tb_main_decoder_fsm;

    localparam int TMO = 16;

    typedef struct packed {
        logic       dv;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [4:0] aop;
        logic [4:0] memi;
        logic       mwe;
        logic       rfwe;
        logic       ws;
        logic       jal;
        logic       jalr;
        logic       b;
        logic       enpc;
        logic       ill;
        logic       mf;
        logic       rdy;
    } obs_t;

    typedef enum int {K_OP, K_IMM, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR,
                      K_LUI, K_AUIPC, K_NOP, K_ILL} kind_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        trap_ack = 1'b0;

    logic        in_ready, dec_valid, mwe, rfwe, ws, jal, jalr, b, enpc, illegal, mem_fault;
    logic [1:0]  srca, state_dbg;
    logic [2:0]  srcb;
    logic [4:0]  aop, memi;

    logic        n_in_ready, n_dec_valid, n_mwe, n_rfwe, n_ws, n_jal, n_jalr, n_b, n_enpc;
    logic        n_illegal, n_mem_fault;
    logic [1:0]  n_srca, n_state_dbg;
    logic [2:0]  n_srcb;
    logic [4:0]  n_aop, n_memi;

    obs_t obs, obs_ns;
    int   n_checks = 0;
    int   n_errors = 0;

    assign obs = {dec_valid, srca, srcb, aop, memi, mwe, rfwe, ws, jal, jalr, b, enpc,
                  illegal, mem_fault, in_ready};
    assign obs_ns = {n_dec_valid, n_srca, n_srcb, n_aop, n_memi, n_mwe, n_rfwe, n_ws, n_jal,
                     n_jalr, n_b, n_enpc, n_illegal, n_mem_fault, n_in_ready};

    main_decoder_fsm #(.MEM_TIMEOUT(TMO), .SYS_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .in_ready(in_ready), .mem_ready(mem_ready), .trap_ack(trap_ack),
        .dec_valid(dec_valid), .srcA(srca), .srcB(srcb), .aop(aop), .memi(memi),
        .mwe(mwe), .rfwe(rfwe), .ws(ws), .jal(jal), .jalr(jalr), .b(b), .enpc(enpc),
        .illegal(illegal), .mem_fault(mem_fault), .state_dbg(state_dbg)
    );

    main_decoder_fsm #(.MEM_TIMEOUT(TMO), .SYS_EN(1'b0)) u_dut_ns (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .in_ready(n_in_ready), .mem_ready(mem_ready), .trap_ack(trap_ack),
        .dec_valid(n_dec_valid), .srcA(n_srca), .srcB(n_srcb), .aop(n_aop), .memi(n_memi),
        .mwe(n_mwe), .rfwe(n_rfwe), .ws(n_ws), .jal(n_jal), .jalr(n_jalr), .b(n_b),
        .enpc(n_enpc), .illegal(n_illegal), .mem_fault(n_mem_fault), .state_dbg(n_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model
    function automatic kind_t classify(input logic [31:0] ins, input bit sys_en);
        logic [6:0] f7;
        f7 = ins[31:25];
        if (ins[1:0] != 2'b11) return K_ILL;
        case (ins[6:0])
            7'h33: return (f7 == 7'h00 || f7 == 7'h20) ? K_OP : K_ILL;
            7'h13: return K_IMM;
            7'h03: return K_LOAD;
            7'h23: return K_STORE;
            7'h63: return K_BR;
            7'h6f: return K_JAL;
            7'h67: return (ins[14:12] == 3'd0) ? K_JALR : K_ILL;
            7'h37: return K_LUI;
            7'h17: return K_AUIPC;
            7'h0f: return K_NOP;
            7'h73: return sys_en ? K_NOP : K_ILL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.rdy = 1'b1;
        return e;
    endfunction

    function automatic obs_t trap_obs(input bit is_fault);
        obs_t e;
        e = '0;
        if (is_fault) e.mf = 1'b1;
        else          e.ill = 1'b1;
        return e;
    endfunction

    // Controls in the cycle after acceptance (for memory ops: the held wait-state view).
    function automatic obs_t exp_accept(input logic [31:0] ins, input bit sys_en);
        obs_t  e;
        kind_t k;
        int    f3, hi;
        e  = '0;
        k  = classify(ins, sys_en);
        f3 = int'(ins[14:12]);
        hi = int'(ins[31:30]);
        if (k == K_ILL) begin
            e.ill = 1'b1;
        end else if (k == K_NOP) begin
            e.dv = 1'b1; e.enpc = 1'b1; e.rdy = 1'b1;
        end else begin
            e.dv = 1'b1; e.enpc = 1'b1; e.rdy = 1'b1;
            e.aop = 5'(f3);
            case (k)
                K_OP:    begin e.rfwe = 1'b1; e.aop = 5'(f3 + 8 * hi); end
                K_IMM:   begin e.sb = 3'd1; e.rfwe = 1'b1; if (f3 == 5) e.aop = 5'(f3 + 8 * hi); end
                K_LOAD:  begin e.sb = 3'd1; e.ws = 1'b1; e.memi = 5'(16 + f3);
                               e.enpc = 1'b0; e.rdy = 1'b0; end
                K_STORE: begin e.sb = 3'd3; e.mwe = 1'b1; e.memi = 5'(24 + f3);
                               e.enpc = 1'b0; e.rdy = 1'b0; end
                K_BR:    begin e.b = 1'b1; e.aop = 5'(24 + f3); end
                K_JAL:   begin e.sa = 2'd1; e.sb = 3'd4; e.rfwe = 1'b1; e.jal = 1'b1; end
                K_JALR:  begin e.sa = 2'd1; e.sb = 3'd4; e.rfwe = 1'b1; e.jalr = 1'b1; end
                K_LUI:   begin e.sa = 2'd2; e.sb = 3'd2; e.rfwe = 1'b1; end
                K_AUIPC: begin e.sa = 2'd1; e.sb = 3'd2; e.rfwe = 1'b1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    // scoreboard check
    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (instr %h)", tag, got, exp, instr);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; trap_ack = 1'b0;
        repeat (2) tick();
        check("reset", obs, idle_obs());
        rst_n = 1'b1;
    endtask

    task automatic do_trap(input int ack_dly, input obs_t held);
        instr_valid = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            trap_ack    = 1'b0;
            mem_ready   = 1'($urandom_range(0, 1));
            instr_valid = 1'($urandom_range(0, 1));
            instr       = $urandom;
            tick();
            check("trap_hold", obs, held);
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        trap_ack    = 1'b1;
        tick();
        trap_ack = 1'b0;
        check("trap_exit", obs, idle_obs());
    endtask

    // wait_len: wait cycles with mem_ready low before it rises (>= TMO means never).
    task automatic run_instr(input logic [31:0] ins, input int wait_len, input int ack_dly);
        obs_t  e, c;
        kind_t k;
        k = classify(ins, 1'b1);
        e = exp_accept(ins, 1'b1);
        instr = ins; instr_valid = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        trap_ack  = 1'($urandom_range(0, 1));
        tick();
        instr_valid = 1'b0; trap_ack = 1'b0;
        check("accept", obs, e);
        instr = ins;
        if (k == K_ILL) begin
            do_trap(ack_dly, trap_obs(1'b0));
        end else if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i < ((wait_len < TMO) ? wait_len : TMO - 1); i++) begin
                mem_ready   = 1'b0;
                instr_valid = 1'($urandom_range(0, 1));
                trap_ack    = 1'($urandom_range(0, 1));
                tick();
                check("mem_wait", obs, e);
            end
            instr_valid = 1'b0; trap_ack = 1'b0;
            if (wait_len < TMO) begin
                mem_ready = 1'b1;
                tick();
                mem_ready = 1'b0;
                c = e;
                c.memi = '0; c.mwe = 1'b0; c.enpc = 1'b1; c.rdy = 1'b1;
                c.rfwe = (k == K_LOAD);
                check("mem_done", obs, c);
            end else begin
                mem_ready = 1'b0;
                tick();
                check("mem_timeout", obs, trap_obs(1'b1));
                do_trap(ack_dly, trap_obs(1'b1));
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] w;
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
        w   = $urandom;
        sel = $urandom_range(0, 12);
        if (sel < 11) w[6:0] = ops[sel];
        if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if (w[6:0] == 7'h67 && $urandom_range(0, 3) != 0) w[14:12] = 3'd0;
        if (sel == 12) w[1:0] = 2'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        obs_t e;

        do_reset();

        // addi x1,x0,5
        e = idle_obs();
        e.dv = 1'b1; e.sb = 3'd1; e.rfwe = 1'b1; e.enpc = 1'b1;
        instr = 32'h0050_0093; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("addi_literal", obs, e);
        run_instr(32'h0050_0093, 0, 0);

        run_instr(32'h0000_A103, 3, 0);          // lw, three wait cycles
        run_instr(32'h0020_A023, TMO, 1);        // sw, mem_ready never comes
        run_instr(32'hFFFF_FFFF, 0, 2);          // illegal word
        run_instr(32'h0080_00EF, 0, 0);          // jal
        run_instr(32'h0000_80E7, 0, 0);          // jalr, no bubble after jal
        run_instr(32'h0000_A103, TMO - 1, 0);    // mem_ready on the expiry cycle
        run_instr(32'h4000_0033, 0, 0);          // sub
        run_instr(32'h4030_5093, 0, 0);          // srai
        run_instr(32'h0020_8463, 0, 0);          // beq
        run_instr(32'h0000_1067, 0, 1);          // jalr func3!=0
        run_instr(32'h0200_0033, 0, 1);          // OP func7=0x01

        // bubble with stray mem_ready/trap_ack in RUN
        instr_valid = 1'b0; mem_ready = 1'b1; trap_ack = 1'b1;
        tick();
        mem_ready = 1'b0; trap_ack = 1'b0;
        check("bubble", obs, idle_obs());

        for (int n = 0; n < 250; n++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                instr_valid = 1'b0; instr = $urandom;
                mem_ready = 1'($urandom_range(0, 1));
                tick();
                check("rand_bubble", obs, idle_obs());
            end
            run_instr(rand_instr(), $urandom_range(0, 20), $urandom_range(0, 3));
        end

        // reset while waiting on the LSU
        instr = 32'h0000_A103; instr_valid = 1'b1; mem_ready = 1'b0;
        tick();
        instr_valid = 1'b0;
        check("rst_mid_accept", obs, exp_accept(32'h0000_A103, 1'b1));
        tick();
        check("rst_mid_wait", obs, exp_accept(32'h0000_A103, 1'b1));
        rst_n = 1'b0;
        tick();
        check("rst_mid", obs, idle_obs());
        rst_n = 1'b1; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rst_mid_after", obs, idle_obs());

        // ecall: NOP with SYS_EN=1, illegal with SYS_EN=0
        do_reset();
        instr = 32'h0000_0073; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        check("ecall_sys_en1", obs, exp_accept(32'h0000_0073, 1'b1));
        check("ecall_sys_en0", obs_ns, exp_accept(32'h0000_0073, 1'b0));
        tick();
        check("ecall_sys_en0_hold", obs_ns, trap_obs(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
